// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the data-memory write-buffer slice.
// Holds the write-buffer entry record and the default geometry.
package dmem_pkg;

    localparam int DMEM_DEPTH      = 64;
    localparam int DMEM_WB_ENTRIES = 4;
    localparam int DMEM_IDX_W      = $clog2(DMEM_DEPTH);

    // Entries carry a full-width word index; unused upper bits stay zero.
    localparam int IDX_MAX_W = 30;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] index;
        logic [31:0]          data;
    } wb_entry_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 backing word array: one synchronous write port, one asynchronous
// read port. Contents are not reset; kept separate so an SRAM macro can drop in.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory responder: stores go through a small write buffer that drains in
// non-load cycles; loads forward from the youngest matching buffered store.
// Optional macro DMEM_WB_COALESCE_EN merges a store into a matching entry.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int WB_ENTRIES = DMEM_WB_ENTRIES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memwrite,
    input  logic                        memread,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wd,
    output logic [31:0]                 rd,
    output logic [$clog2(WB_ENTRIES):0] wb_count,
    output logic                        wb_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = ptr_w(WB_ENTRIES);
    localparam int CNT_W = cnt_w(WB_ENTRIES);

    wb_entry_t            ent_q [WB_ENTRIES];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [IDX_W-1:0]     word_idx;
    logic [IDX_MAX_W-1:0] idx;
    logic                 drain;
    logic                 coalesce;
    logic                 alloc;
    logic                 hit;
    logic [PTR_W-1:0]     hit_ptr;
    logic [31:0]          arr_rdata;
    logic                 unused_addr;

    assign word_idx    = addr[IDX_W+1:2];
    assign idx         = IDX_MAX_W'(word_idx);
    assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

    // A full buffer drains even under a load, so a store always finds a slot.
    assign drain = (count_q != '0) && (!memread || count_q == CNT_W'(WB_ENTRIES));

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit     = 1'b0;
        hit_ptr = '0;
        for (int k = 0; k < WB_ENTRIES; k++) begin
            if (ent_q[head_q + PTR_W'(k)].valid &&
                ent_q[head_q + PTR_W'(k)].index == idx) begin
                hit     = 1'b1;
                hit_ptr = head_q + PTR_W'(k);
            end
        end
    end

`ifdef DMEM_WB_COALESCE_EN
    // The head leaves at this edge when draining, so merging into it would lose the store.
    assign coalesce = memwrite && hit && !(drain && hit_ptr == head_q);
`else
    assign coalesce = 1'b0;
`endif

    assign alloc = memwrite && !coalesce;

    always_comb begin
        head_d  = drain ? head_q + PTR_W'(1) : head_q;
        tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (alloc && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (!alloc && drain) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < WB_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (drain) begin
                ent_q[head_q].valid <= 1'b0;
            end
            if (coalesce) begin
                ent_q[hit_ptr].data <= wd;
            end
            // Must follow the drain clear: when full, tail and head share a slot.
            if (alloc) begin
                ent_q[tail_q] <= '{valid: 1'b1, index: idx, data: wd};
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (drain),
        .waddr_i (ent_q[head_q].index[IDX_W-1:0]),
        .wdata_i (ent_q[head_q].data),
        .raddr_i (word_idx),
        .rdata_o (arr_rdata)
    );

    assign rd       = hit ? ent_q[hit_ptr].data : arr_rdata;
    assign wb_count = count_q;
    assign wb_empty = (count_q == '0);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: a vector table of per-cycle inputs with
// expected rd / occupancy, plus a hand-written mid-operation reset sequence.
module tb_dmem_wbuf;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite, memread;
    logic [31:0] addr, wd;
    logic [31:0] rd;
    logic [2:0]  wb_count;
    logic        wb_empty;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef DMEM_WB_COALESCE_EN
    localparam int COAL = 1;
`else
    localparam int COAL = 0;
`endif

    typedef struct {
        logic        mw;
        logic        mr;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_cnt;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    dmem_wbuf #(
        .DEPTH      (64),
        .WB_ENTRIES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .memread  (memread),
        .addr     (addr),
        .wd       (wd),
        .rd       (rd),
        .wb_count (wb_count),
        .wb_empty (wb_empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Inputs apply for one cycle; checks see the state from before this cycle's edge.
    task automatic step(input logic mw, input logic mr, input logic [31:0] a,
                        input logic [31:0] d, input logic c_rd, input logic [31:0] e_rd,
                        input int e_cnt, input string nm);
        @(posedge clk);
        #1;
        memwrite = mw;
        memread  = mr;
        addr     = a;
        wd       = d;
        @(negedge clk);
        if (c_rd) chk({nm, " rd"}, rd, e_rd);
        chk({nm, " cnt"}, 32'(wb_count), 32'(e_cnt));
        chk({nm, " empty"}, 32'(wb_empty), (e_cnt == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        memwrite = 1'b0;
        memread  = 1'b0;
        addr     = '0;
        wd       = '0;

        // mw mr addr d chk_rd exp_rd exp_cnt
        vq.push_back('{1, 0, 32'h10, 32'hCAFEBABE, 0, 32'h0,        0});
        vq.push_back('{0, 0, 32'h10, 32'h0,        1, 32'hCAFEBABE, 1});
        vq.push_back('{0, 0, 32'h10, 32'h0,        1, 32'hCAFEBABE, 0});
        vq.push_back('{0, 1, 32'h10, 32'h0,        1, 32'hCAFEBABE, 0});
        vq.push_back('{1, 0, 32'h20, 32'h11111111, 0, 32'h0,        0});
        vq.push_back('{0, 1, 32'h20, 32'h0,        1, 32'h11111111, 1});
        vq.push_back('{0, 0, 32'h20, 32'h0,        1, 32'h11111111, 1});
        vq.push_back('{0, 0, 32'h20, 32'h0,        1, 32'h11111111, 0});
        vq.push_back('{1, 1, 32'h40, 32'hA,        0, 32'h0,        0});
        vq.push_back('{1, 1, 32'h40, 32'hB,        1, 32'hA,        1});
        vq.push_back('{0, 1, 32'h40, 32'h0,        1, 32'hB,        2 - COAL});
        vq.push_back('{0, 1, 32'h40, 32'h0,        1, 32'hB,        2 - COAL});
        vq.push_back('{0, 0, 32'h40, 32'h0,        1, 32'hB,        2 - COAL});
        vq.push_back('{0, 0, 32'h40, 32'h0,        1, 32'hB,        1 - COAL});
        vq.push_back('{0, 0, 32'h40, 32'h0,        1, 32'hB,        0});
        vq.push_back('{1, 1, 32'h80, 32'h100,      0, 32'h0,        0});
        vq.push_back('{1, 1, 32'h84, 32'h101,      0, 32'h0,        1});
        vq.push_back('{1, 1, 32'h88, 32'h102,      0, 32'h0,        2});
        vq.push_back('{1, 1, 32'h8C, 32'h103,      0, 32'h0,        3});
        vq.push_back('{1, 1, 32'h90, 32'h104,      0, 32'h0,        4});
        vq.push_back('{0, 1, 32'h80, 32'h0,        1, 32'h100,      4});
        vq.push_back('{0, 1, 32'h90, 32'h0,        1, 32'h104,      3});
        vq.push_back('{0, 0, 32'h84, 32'h0,        1, 32'h101,      3});
        vq.push_back('{0, 0, 32'h88, 32'h0,        1, 32'h102,      2});
        vq.push_back('{0, 0, 32'h8C, 32'h0,        1, 32'h103,      1});
        vq.push_back('{0, 0, 32'h90, 32'h0,        1, 32'h104,      0});
        vq.push_back('{0, 0, 32'h80, 32'h0,        1, 32'h100,      0});
        vq.push_back('{1, 0, 32'h100, 32'h5,       0, 32'h0,        0});
        vq.push_back('{0, 1, 32'h000, 32'h0,       1, 32'h5,        1});
        vq.push_back('{0, 0, 32'h000, 32'h0,       1, 32'h5,        1});
        vq.push_back('{0, 0, 32'h000, 32'h0,       1, 32'h5,        0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cnt", 32'(wb_count), 32'd0);
        chk("reset empty", 32'(wb_empty), 32'd1);
        reset = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].mw, vq[i].mr, vq[i].a, vq[i].d, vq[i].chk_rd,
                 vq[i].exp_rd, vq[i].exp_cnt, $sformatf("row%0d", i));
        end

        // Reset with three undrained stores over previously written words.
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 32'hA0 + 32'(4 * k), 32'hAAAA0000 + 32'(k), 0, 32'h0, 0,
                 $sformatf("pre%0d st", k));
            step(0, 0, 32'hA0 + 32'(4 * k), 32'h0, 1, 32'hAAAA0000 + 32'(k), 1,
                 $sformatf("pre%0d ld", k));
        end
        step(1, 1, 32'hA0, 32'hDEAD0000, 0, 32'h0,        0, "pend0");
        step(1, 1, 32'hA4, 32'hDEAD0001, 1, 32'hAAAA0001, 1, "pend1");
        step(1, 1, 32'hA8, 32'hDEAD0002, 1, 32'hAAAA0002, 2, "pend2");
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        memread  = 1'b1;
        addr     = 32'hA0;
        #2;
        chk("pend cnt", 32'(wb_count), 32'd3);
        chk("pend rd", rd, 32'hDEAD0000);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst cnt", 32'(wb_count), 32'd0);
        chk("midrst empty", 32'(wb_empty), 32'd1);
        chk("midrst rd", rd, 32'hAAAA0000);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 32'hA0, 32'h0, 1, 32'hAAAA0000, 0, "post0");
        step(0, 0, 32'hA4, 32'h0, 1, 32'hAAAA0001, 0, "post1");
        step(0, 0, 32'hA8, 32'h0, 1, 32'hAAAA0002, 0, "post2");

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
